// File: rtl/sw_input_pkg.sv
// Shared register map and field layout for the sw_input switch peripheral.
// The byte offsets below define the register index decoded from mem_addr[3:2].
package sw_input_pkg;

   localparam logic [3:0] OFF_STATE  = 4'h0;
   localparam logic [3:0] OFF_RISE   = 4'h4;
   localparam logic [3:0] OFF_FALL   = 4'h8;
   localparam logic [3:0] OFF_IRQ_EN = 4'hC;

   // IRQ_EN layout: rise enables start at bit 0, fall enables start at bit 16.
   localparam int RISE_EN_LSB = 0;
   localparam int FALL_EN_LSB = 16;

   typedef enum logic [1:0] {
      REG_STATE  = OFF_STATE[3:2],
      REG_RISE   = OFF_RISE[3:2],
      REG_FALL   = OFF_FALL[3:2],
      REG_IRQ_EN = OFF_IRQ_EN[3:2]
   } reg_sel_e;

   function automatic reg_sel_e decode_addr(input logic [3:0] addr);
      return reg_sel_e'(addr[3:2]);
   endfunction

   function automatic int cnt_width(input int debounce);
      int w;
      w = $clog2(debounce + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: two-flop synchronizer followed by a consecutive-cycle
// debounce counter; flags the edge on which the stable level changes.
module sw_debounce
   import sw_input_pkg::*;
#(
   parameter int DEBOUNCE = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic stable,
   output logic set_rise,
   output logic set_fall
);

   localparam int               CNT_W    = cnt_width(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic             sync_meta;
   logic             sync;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             accept;

   assign differ   = (sync != stable);
   assign accept   = differ && (cnt == CNT_LAST);
   assign set_rise = accept && sync;
   assign set_fall = accept && !sync;

   // NOTE: non-blocking assignments let both synchronizer stages shift on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         cnt       <= '0;
         stable    <= 1'b0;
      end else begin
         sync_meta <= sw_raw;
         sync      <= sync_meta;
         // Any cycle of agreement restarts the count; acceptance also clears it.
         if (!differ || accept) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         if (accept) begin
            stable <= sync;
         end
      end
   end

endmodule

// File: rtl/sw_input.sv
// Debounced switch bank with sticky RISE/FALL event registers, per-event
// interrupt enables and a single-cycle-acknowledge memory-mapped bus port.
module sw_input
   import sw_input_pkg::*;
#(
   parameter int N_SW     = 4,
   parameter int DEBOUNCE = 50000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_SW-1:0] sw_in,
   input  logic            mem_valid,
   input  logic [3:0]      mem_addr,
   input  logic [3:0]      mem_wstrb,
   input  logic [31:0]     mem_wdata,
   output logic [31:0]     mem_rdata,
   output logic            mem_ready,
   output logic            irq
);

   logic [N_SW-1:0] stable;
   logic [N_SW-1:0] set_rise;
   logic [N_SW-1:0] set_fall;
   logic [N_SW-1:0] rise_q;
   logic [N_SW-1:0] fall_q;
   logic [N_SW-1:0] en_rise_q;
   logic [N_SW-1:0] en_fall_q;
   logic [N_SW-1:0] w1c_rise;
   logic [N_SW-1:0] w1c_fall;
   logic [31:0]     rd_word;
   logic            wr_en;
   reg_sel_e        sel;
   logic            unused_bits;

   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      sw_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_deb (
         .clk      (clk),
         .reset    (reset),
         .sw_raw   (sw_in[i]),
         .stable   (stable[i]),
         .set_rise (set_rise[i]),
         .set_fall (set_fall[i])
      );
   end

   assign sel   = decode_addr(mem_addr);
   // A write commits on the edge that ends its acknowledge cycle.
   assign wr_en = mem_ready && mem_valid && (mem_wstrb != 4'b0000);

   assign w1c_rise = (wr_en && sel == REG_RISE) ? mem_wdata[N_SW-1:0] : '0;
   assign w1c_fall = (wr_en && sel == REG_FALL) ? mem_wdata[N_SW-1:0] : '0;

   always_comb begin
      // NOTE: default first so every path assigns rd_word and no latch is inferred.
      rd_word = '0;
      case (sel)
         REG_STATE:  rd_word[N_SW-1:0] = stable;
         REG_RISE:   rd_word[N_SW-1:0] = rise_q;
         REG_FALL:   rd_word[N_SW-1:0] = fall_q;
         REG_IRQ_EN: begin
            rd_word[RISE_EN_LSB +: N_SW] = en_rise_q;
            rd_word[FALL_EN_LSB +: N_SW] = en_fall_q;
         end
      endcase
   end

   assign mem_rdata = mem_ready ? rd_word : '0;
   assign irq       = (|(rise_q & en_rise_q)) | (|(fall_q & en_fall_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_ready <= 1'b0;
         rise_q    <= '0;
         fall_q    <= '0;
         en_rise_q <= '0;
         en_fall_q <= '0;
      end else begin
         mem_ready <= mem_valid && !mem_ready;
         // A new edge event beats a same-cycle clear of the same bit.
         rise_q    <= (rise_q & ~w1c_rise) | set_rise;
         fall_q    <= (fall_q & ~w1c_fall) | set_fall;
         if (wr_en && sel == REG_IRQ_EN) begin
            en_rise_q <= mem_wdata[RISE_EN_LSB +: N_SW];
            en_fall_q <= mem_wdata[FALL_EN_LSB +: N_SW];
         end
      end
   end

   assign unused_bits = ^{mem_addr[1:0], mem_wdata};

endmodule

// File: tb/tb_sw_input.sv
// Randomized and directed bench for sw_input with a window-based debounce
// reference model and a read-data scoreboard checked by an independent monitor.
module tb_sw_input;

   localparam int N_SW = 4;
   localparam int DEB  = 8;

   logic            clk       = 1'b0;
   logic            reset     = 1'b1;
   logic [N_SW-1:0] sw_in     = '0;
   logic            mem_valid = 1'b0;
   logic [3:0]      mem_addr  = '0;
   logic [3:0]      mem_wstrb = '0;
   logic [31:0]     mem_wdata = '0;
   logic [31:0]     mem_rdata;
   logic            mem_ready;
   logic            irq;

   sw_input #(
      .N_SW     (N_SW),
      .DEBOUNCE (DEB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_in     (sw_in),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a channel flips once the synchronized input (raw input
   // two edges earlier) has disagreed with the stable level on each of the
   // last DEB edges, all of them after the previous flip or reset.
   logic [N_SW-1:0] m_stable, m_rise, m_fall, m_en_r, m_en_f;
   logic            m_ready;
   logic [N_SW-1:0] hist[$];
   int              age[N_SW];
   logic [31:0]     exp_q[$];

   function automatic logic [31:0] m_reg(input logic [3:0] addr);
      logic [31:0] v;
      v = '0;
      case (addr[3:2])
         2'd0: v[N_SW-1:0] = m_stable;
         2'd1: v[N_SW-1:0] = m_rise;
         2'd2: v[N_SW-1:0] = m_fall;
         default: begin
            v[N_SW-1:0]  = m_en_r;
            v[16 +: N_SW] = m_en_f;
         end
      endcase
      return v;
   endfunction

   function automatic logic m_irq();
      return (|(m_rise & m_en_r)) || (|(m_fall & m_en_f));
   endfunction

   task automatic model_clear();
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_en_r   = '0;
      m_en_f   = '0;
      m_ready  = 1'b0;
      hist.delete();
      repeat (DEB + 2) hist.push_back('0);
      foreach (age[i]) age[i] = 0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      logic [N_SW-1:0] set_r = '0;
      logic [N_SW-1:0] set_f = '0;
      logic [N_SW-1:0] clr_r = '0;
      logic [N_SW-1:0] clr_f = '0;
      bit              flip;
      hist.push_back(sw_in);
      if (hist.size() > DEB + 3) void'(hist.pop_front());
      for (int i = 0; i < N_SW; i++) begin
         age[i]++;
         if (age[i] >= DEB) begin
            flip = 1'b1;
            for (int t = 0; t < DEB; t++)
               if (hist[hist.size() - 3 - t][i] == m_stable[i]) flip = 1'b0;
            if (flip) begin
               m_stable[i] = ~m_stable[i];
               age[i]      = 0;
               if (m_stable[i]) set_r[i] = 1'b1;
               else             set_f[i] = 1'b1;
            end
         end
      end
      if (m_ready && mem_valid && mem_wstrb != 4'h0) begin
         case (mem_addr[3:2])
            2'd1: clr_r = mem_wdata[N_SW-1:0];
            2'd2: clr_f = mem_wdata[N_SW-1:0];
            2'd3: begin
               m_en_r = mem_wdata[N_SW-1:0];
               m_en_f = mem_wdata[16 +: N_SW];
            end
            default: ;
         endcase
      end
      m_rise = (m_rise & ~clr_r) | set_r;
      m_fall = (m_fall & ~clr_f) | set_f;
      if (mem_valid && !m_ready) begin
         m_ready = 1'b1;
         exp_q.push_back(m_reg(mem_addr));
      end else begin
         m_ready = 1'b0;
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_clear();
         else       model_edge();
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: compares DUT outputs against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      check("mem_ready", 32'(mem_ready), 32'(m_ready));
      check("irq", 32'(irq), 32'(m_irq()));
      if (mem_ready && exp_q.size() > 0) begin
         check("mem_rdata", mem_rdata, exp_q.pop_front());
      end else if (!mem_ready) begin
         check("mem_rdata_idle", mem_rdata, 32'h0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [3:0] addr, input logic [3:0] strb,
                      input logic [31:0] wdata, output logic [31:0] rdata);
      int waited;
      waited    = 0;
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wstrb = strb;
      mem_wdata = wdata;
      do begin
         tick(1);
         waited++;
      end while (!mem_ready && waited < 8);
      check("bus_ack", 32'(mem_ready), 32'h1);
      rdata = mem_rdata;
      tick(1);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      bus(addr, 4'hF, data, dummy);
   endtask

   task automatic rd(input logic [3:0] addr, output logic [31:0] data);
      bus(addr, 4'h0, 32'h0, data);
   endtask

   task automatic wait_irq(input int c0, input int exp_edges, input string name);
      int b;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (!irq && b < 40);
      check(name, 32'(cyc - c0), 32'(exp_edges));
      tick(1);
   endtask

   initial begin
      logic [31:0] rd_v;
      logic [3:0]  a;
      logic [5:0]  pat;
      int          c0;

      tick(3);
      check("rst_ready", 32'(mem_ready), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rdata", mem_rdata, 32'h0);
      reset = 1'b0;
      tick(2);

      // Clean step on channel 0: stable and RISE follow 2 + DEB edges later.
      wr(4'hC, 32'h1);
      c0 = cyc;
      sw_in = 4'b0001;
      wait_irq(c0, 10, "rise_latency");
      wr(4'hC, 32'h0);
      rd(4'h0, rd_v);  check("state_after_step", rd_v, 32'h1);
      rd(4'h4, rd_v);  check("rise_after_step", rd_v, 32'h1);
      check("irq_disabled", 32'(irq), 32'h0);

      // Bouncing channel 2 never settles long enough to be accepted.
      wr(4'h4, 32'hF);
      wr(4'h8, 32'hF);
      for (int k = 0; k < 20; k++) begin
         sw_in[2] = ~sw_in[2];
         tick(5);
      end
      tick(12);
      rd(4'h0, rd_v);  check("bounce_state2", 32'(rd_v[2]), 32'h0);
      rd(4'h4, rd_v);  check("bounce_rise2", 32'(rd_v[2]), 32'h0);
      rd(4'h8, rd_v);  check("bounce_fall2", 32'(rd_v[2]), 32'h0);

      // Fall interrupt masking, enabling and clearing on channel 1.
      wr(4'hC, 32'h0001_0000);
      sw_in[1] = 1'b1;
      tick(14);
      wr(4'h4, 32'hF);
      wr(4'h8, 32'hF);
      sw_in[1] = 1'b0;
      tick(14);
      rd(4'h8, rd_v);  check("fall_ch1", rd_v, 32'h2);
      check("irq_fall_masked", 32'(irq), 32'h0);
      wr(4'hC, 32'h0002_0000);
      check("irq_fall_enabled", 32'(irq), 32'h1);
      wr(4'h8, 32'h2);
      check("irq_after_w1c", 32'(irq), 32'h0);

      // W1C of RISE[3] committing on the very edge stable[3] rises.
      wr(4'hC, 32'h0);
      wr(4'h4, 32'hF);
      sw_in[3] = 1'b1;
      tick(8);
      wr(4'h4, 32'h8);
      rd(4'h4, rd_v);  check("rise3_set_wins", rd_v, 32'h8);

      // Held request: acknowledge every other cycle.
      mem_valid = 1'b1;
      mem_addr  = 4'h0;
      mem_wstrb = 4'h0;
      pat = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         pat = {pat[4:0], mem_ready};
      end
      tick(1);
      mem_valid = 1'b0;
      check("ready_pattern", 32'(pat), 32'h15);
      rd(4'h4, rd_v);  check("rise_unused_bits", rd_v >> 4, 32'h0);

      // Reset during a write acknowledge, with channel 0 mid-count.
      wr(4'hC, 32'h000F_0000);
      sw_in = '0;
      tick(14);
      sw_in[0] = 1'b1;
      tick(6);
      mem_valid = 1'b1;
      mem_addr  = 4'hC;
      mem_wstrb = 4'hF;
      mem_wdata = 32'h000F_000F;
      tick(1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ready", 32'(mem_ready), 32'h0);
      check("async_rst_irq", 32'(irq), 32'h0);
      check("async_rst_rdata", mem_rdata, 32'h0);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      tick(3);
      reset = 1'b0;
      c0 = cyc;
      rd(4'hC, rd_v);  check("irq_en_aborted", rd_v, 32'h0);
      rd(4'h4, rd_v);  check("rise_cleared", rd_v, 32'h0);
      wr(4'hC, 32'h1);
      wait_irq(c0, 10, "rise_after_reset");

      // Randomized switch activity interleaved with bus traffic.
      wr(4'h4, 32'hF);
      wr(4'h8, 32'hF);
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 2) == 0) sw_in = N_SW'($urandom);
         a = 4'($urandom);
         case ($urandom_range(0, 3))
            0:       rd(a, rd_v);
            1:       bus(a, 4'($urandom_range(1, 15)), $urandom, rd_v);
            default: tick($urandom_range(1, 12));
         endcase
      end

      tick(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
